mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_div_iter.sv | 67 ++++++
 rtl/mdu_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit: op codes, FSM states, divide length.
// Pure definitions; no timing or backpressure of its own.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  localparam int DIV_ITER = 32;

  function automatic logic op_is_mul(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider on operand magnitudes: one quotient bit per step_i, DIV_ITER steps after start_i.
// Signed results are formed combinationally from the latched signs; caller paces it via step_i.
module mdu_div_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        step_i,
  output logic        last_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int ITER_W = $clog2(DIV_ITER);

  logic [31:0]       rem_q, quo_q, dvs_q;
  logic [31:0]       rem_d, quo_d;
  logic [ITER_W-1:0] iter_q;
  logic              neg_q_q, neg_r_q;
  logic              a_neg, b_neg, fits;

  assign a_neg = signed_i & dividend_i[31];
  assign b_neg = signed_i & divisor_i[31];

  // The partial remainder can reach 33 bits before the trial subtract, hence the wide compare.
  assign fits = {rem_q, quo_q[31]} >= {1'b0, dvs_q};

  always_comb begin
    rem_d = {rem_q[30:0], quo_q[31]};
    quo_d = {quo_q[30:0], 1'b0};
    if (fits) begin
      rem_d    = {rem_q[30:0], quo_q[31]} - dvs_q;
      quo_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      iter_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (start_i) begin
      rem_q   <= '0;
      quo_q   <= a_neg ? -dividend_i : dividend_i;
      dvs_q   <= b_neg ? -divisor_i : divisor_i;
      iter_q  <= '0;
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
    end else if (step_i) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      iter_q <= iter_q + ITER_W'(1);
    end
  end

  assign last_o = iter_q == ITER_W'(DIV_ITER - 1);
  assign quot_o = neg_q_q ? -quo_q : quo_q;
  assign rem_o  = neg_r_q ? -rem_q : rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide controller: MUL_LAT+1 cycles for multiplies, 34 for divides, moves in 1.
// Accepts only when idle; stall holds the pipeline while busy and an op or MFHI/MFLO is waiting.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        rd_req,
  input  logic        rd_sel,
  input  logic        flush,
  output logic        mul_start,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] LAT_C = 4'(MUL_LAT);

  mdu_state_e  state_q;
  logic [3:0]  op_q, lat_q;
  logic [31:0] hi_q, lo_q;
  logic [63:0] acc_d;
  logic        accept, acc_div, div_zero, div_step, div_last;
  logic [31:0] div_quot, div_rem;

  // Reset gates acceptance so nothing leaks out while rst is low.
  assign accept   = rst & (state_q == ST_IDLE) & op_valid & ~flush;
  assign acc_div  = accept & ((op == OP_DIV) || (op == OP_DIVU));
  assign div_zero = src_b == '0;
  assign div_step = (state_q == ST_DIV) & ~flush;

  assign mul_start = accept & op_is_mul(op);
  assign mul_sign  = op_is_signed(op);
  assign mul_a     = src_a;
  assign mul_b     = src_b;

  assign busy    = state_q != ST_IDLE;
  assign stall   = busy & (op_valid | rd_req);
  assign rd_data = rd_sel ? hi_q : lo_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

  always_comb begin
    acc_d = mul_p;
    case (op_q)
      OP_MADD, OP_MADDU: acc_d = {hi_q, lo_q} + mul_p;
      OP_MSUB, OP_MSUBU: acc_d = {hi_q, lo_q} - mul_p;
      default:           acc_d = mul_p;
    endcase
  end

  mdu_div_iter u_div (
    .clk        (clk),
    .rst_ni     (rst),
    .start_i    (acc_div & ~div_zero),
    .signed_i   (op == OP_DIV),
    .dividend_i (src_a),
    .divisor_i  (src_b),
    .step_i     (div_step),
    .last_o     (div_last),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      lat_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi_q <= src_a;
              OP_MTLO: lo_q <= src_a;
              OP_DIV, OP_DIVU: begin
                if (div_zero) begin
                  hi_q <= src_a;
                  lo_q <= '1;
                end else begin
                  state_q <= ST_DIV;
                end
              end
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                op_q    <= op;
                lat_q   <= 4'd1;
                state_q <= ST_MUL;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (flush) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
          end else if (lat_q == LAT_C) begin
            {hi_q, lo_q} <= acc_d;
            state_q      <= ST_IDLE;
            lat_q        <= '0;
          end else begin
            lat_q <= lat_q + 4'd1;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (div_last) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!flush) begin
            hi_q <= div_rem;
            lo_q <= div_quot;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
